// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module : serial_adder_pkg
// Brief  : Shared FSM state type and sizing helper for the digit-serial adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step counter width; a single-step adder still needs a 1-bit counter.
    function automatic int calc_cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// ============================================================================
// Module : digit_adder
// Brief  : Combinational DIGIT-bit ripple adder built from full-adder cells.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    endgenerate

    assign o_cout = w_c[DIGIT];
    // Carry into the top cell; on the final digit this is the carry into the MSB.
    assign o_cmsb = w_c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module : serial_adder
// Brief  : Digit-serial WIDTH-bit adder, LSD first, start/busy/done handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = calc_cw(N);
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic             w_dcmsb;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_shift;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_dsum),
        .o_cout (w_dcout),
        .o_cmsb (w_dcmsb)
    );

    // Requests are taken in IDLE and DONE alike, giving gap-free back-to-back ops.
    assign w_accept    = (r_state != ST_RUN) && start;
    assign w_last      = (r_cnt == c_last);
    assign w_sum_shift = WIDTH'({w_dsum, r_sum} >> DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = start  ? ST_RUN  : ST_IDLE;
            ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_next = start  ? ST_RUN  : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_shift;
            r_carry <= w_dcout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_dcout;
                r_ovf  <= w_dcmsb ^ w_dcout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module : tb_serial_adder
// Brief  : Self-checking bench: six adder configurations against a cycle model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_adder;

    localparam int NI = 6;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [NI-1:0]   st    = '0;
    logic [NI-1:0]   ci    = '0;
    logic [15:0]     av [NI];
    logic [15:0]     bv [NI];
    logic [NI-1:0]   bz, dn, co, ov;
    logic [7:0]      s0, s1;
    logic [15:0]     s2, s3, s4, s5;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8),  .DIGIT(1))  u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]), .cin(ci[0]), .busy(bz[0]), .done(dn[0]), .sum(s0), .cout(co[0]), .ovf(ov[0]));
    serial_adder #(.WIDTH(8),  .DIGIT(4))  u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][7:0]), .b(bv[1][7:0]), .cin(ci[1]), .busy(bz[1]), .done(dn[1]), .sum(s1), .cout(co[1]), .ovf(ov[1]));
    serial_adder #(.WIDTH(16), .DIGIT(1))  u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]), .cin(ci[2]), .busy(bz[2]), .done(dn[2]), .sum(s2), .cout(co[2]), .ovf(ov[2]));
    serial_adder #(.WIDTH(16), .DIGIT(2))  u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .a(av[3]), .b(bv[3]), .cin(ci[3]), .busy(bz[3]), .done(dn[3]), .sum(s3), .cout(co[3]), .ovf(ov[3]));
    serial_adder #(.WIDTH(16), .DIGIT(4))  u4 (.clk(clk), .rst_n(rst_n), .start(st[4]), .a(av[4]), .b(bv[4]), .cin(ci[4]), .busy(bz[4]), .done(dn[4]), .sum(s4), .cout(co[4]), .ovf(ov[4]));
    serial_adder #(.WIDTH(16), .DIGIT(16)) u5 (.clk(clk), .rst_n(rst_n), .start(st[5]), .a(av[5]), .b(bv[5]), .cin(ci[5]), .busy(bz[5]), .done(dn[5]), .sum(s5), .cout(co[5]), .ovf(ov[5]));

    function automatic int wof(int k);
        return (k < 2) ? 8 : 16;
    endfunction

    function automatic int nof(int k);
        case (k)
            0: return 8;
            1: return 2;
            2: return 16;
            3: return 8;
            4: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] dut_sum(int k);
        case (k)
            0: return {8'h00, s0};
            1: return {8'h00, s1};
            2: return s2;
            3: return s3;
            4: return s4;
            default: return s5;
        endcase
    endfunction

    // Reference result {ovf, cout, sum} from plain integer addition.
    function automatic logic [17:0] ref_add(int w, logic [15:0] x, logic [15:0] y, logic c);
        logic [16:0] m;
        logic [16:0] f;
        logic [15:0] s;
        logic        o;
        m = (17'd1 << w) - 17'd1;
        f = ({1'b0, x} & m) + ({1'b0, y} & m) + {16'd0, c};
        s = f[15:0] & m[15:0];
        o = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {o, f[w], s};
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Model: cnt = edges since acceptance (0 idle, 1..N busy, N+1 done cycle).
    int          cnt [NI]       = '{default: 0};
    int          exp_dones [NI] = '{default: 0};
    int          dut_dones [NI] = '{default: 0};
    logic [15:0] es [NI]        = '{default: '0};
    logic [15:0] ps [NI]        = '{default: '0};
    logic        eco [NI]       = '{default: 1'b0};
    logic        eov [NI]       = '{default: 1'b0};
    logic        pco [NI]       = '{default: 1'b0};
    logic        pov [NI]       = '{default: 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                cnt[k] <= 0;
                es[k]  <= '0;
                eco[k] <= 1'b0;
                eov[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (cnt[k] == 0 || cnt[k] == nof(k) + 1) begin
                    if (st[k]) begin
                        {pov[k], pco[k], ps[k]} <= ref_add(wof(k), av[k], bv[k], ci[k]);
                        cnt[k] <= 1;
                    end else begin
                        cnt[k] <= 0;
                    end
                end else begin
                    cnt[k] <= cnt[k] + 1;
                    if (cnt[k] == nof(k)) begin
                        es[k]        <= ps[k];
                        eco[k]       <= pco[k];
                        eov[k]       <= pov[k];
                        exp_dones[k] <= exp_dones[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("busy", k, 32'(bz[k]), 32'(cnt[k] >= 1 && cnt[k] <= nof(k)));
            chk("done", k, 32'(dn[k]), 32'(cnt[k] == nof(k) + 1));
            chk("cout", k, 32'(co[k]), 32'(eco[k]));
            chk("ovf",  k, 32'(ov[k]), 32'(eov[k]));
            if (cnt[k] == 0 || cnt[k] == nof(k) + 1)
                chk("sum", k, 32'(dut_sum(k)), 32'(es[k]));
            if (dn[k]) dut_dones[k]++;
        end
    end

    task automatic wait_done(int k);
        int g;
        g = 0;
        while (!dn[k] && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!dn[k]) chk("done_timeout", k, 32'd0, 32'd1);
    endtask

    // One operation from idle; checks latency in edges and literal results.
    task automatic run(int k, logic [15:0] x, logic [15:0] y, logic c,
                       logic [15:0] xs, logic xco, logic xov);
        int edges;
        @(negedge clk);
        av[k] = x; bv[k] = y; ci[k] = c; st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0; av[k] = ~x; bv[k] = x ^ y; ci[k] = ~c;
        edges = 0;
        while (!dn[k] && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        chk("latency", k, 32'(edges), 32'(nof(k)));
        chk("res_sum", k, 32'(dut_sum(k)), 32'(xs));
        chk("res_cout", k, 32'(co[k]), 32'(xco));
        chk("res_ovf", k, 32'(ov[k]), 32'(xov));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        logic [17:0] r;
        logic [15:0] x, y;
        logic        c;
        for (int k = 0; k < NI; k++) begin
            av[k] = '0;
            bv[k] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 32'(bz[0]), 32'd0);
        chk("rst_sum",  2, 32'(s2), 32'd0);
        chk("rst_cout", 2, 32'(co[2]), 32'd0);
        rst_n = 1'b1;

        run(0, 16'h3C, 16'h5A, 1'b0, 16'h96, 1'b0, 1'b1);
        run(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0);
        run(0, 16'h80, 16'h80, 1'b1, 16'h01, 1'b1, 1'b1);

        // Abort on the 4th RUN cycle; prior result has cout=ovf=1, sum=0x01.
        @(negedge clk);
        av[0] = 16'h12; bv[0] = 16'h34; ci[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 0, 32'(bz[0]), 32'd0);
        chk("abort_done", 0, 32'(dn[0]), 32'd0);
        chk("abort_sum",  0, 32'(s0), 32'd0);
        chk("abort_cout", 0, 32'(co[0]), 32'd0);
        chk("abort_ovf",  0, 32'(ov[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(0, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 1'b0);

        run(1, 16'h7F, 16'h00, 1'b1, 16'h80, 1'b0, 1'b1);
        run(5, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run(3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Start held high: ignored while busy, re-accepted in the DONE cycle.
        @(negedge clk);
        av[0] = 16'h10; bv[0] = 16'h20; ci[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        av[0] = 16'h01; bv[0] = 16'h02;
        wait_done(0);
        t1 = cyc;
        chk("b2b_sum1", 0, 32'(s0), 32'h30);
        @(negedge clk);
        wait_done(0);
        t2 = cyc;
        st[0] = 1'b0;
        chk("b2b_gap", 0, 32'(t2 - t1), 32'd9);
        chk("b2b_sum2", 0, 32'(s0), 32'h03);

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                c = 1'($urandom);
                r = ref_add(wof(k), x, y, c);
                run(k, x, y, c, r[15:0], r[16], r[17]);
            end
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++)
            chk("done_count", k, 32'(dut_dones[k]), 32'(exp_dones[k]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
